// File: rtl/sha_pkg.sv
// Shared widths and pager state encoding for the digest read-out path.
package sha_pkg;

    localparam int unsigned DIGEST_W   = 256;
    localparam int unsigned PAGE_W     = 32;
    localparam int unsigned NUM_PAGES  = 8;
    localparam int unsigned PAGE_IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } pager_state_e;

endpackage

// File: rtl/button_debouncer.sv
// Synchronises a raw push-button, filters bounce, and emits a one-cycle press pulse.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                press_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser and filter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/hash_digest_pager.sv
// Captures the 256-bit digest on round completion and pages it out 32 bits at a time.
module hash_digest_pager
    import sha_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES    = 1_000_000,
    parameter int unsigned AUTO_SCROLL_CYCLES = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rounds_done,
    input  logic [DIGEST_W-1:0]   hash,
    input  logic                  next_page,
    input  logic                  prev_page,
    input  logic                  auto_en,
    output logic [PAGE_W-1:0]     page_nibbles,
    output logic [PAGE_IDX_W-1:0] page_idx,
    output logic                  digest_valid,
    output logic                  page_tick
);

    localparam bit          AUTO_ON = (AUTO_SCROLL_CYCLES != 0);
    localparam int unsigned AUTO_W  = (AUTO_SCROLL_CYCLES > 1) ? $clog2(AUTO_SCROLL_CYCLES) : 1;
    localparam logic [AUTO_W-1:0] AUTO_LAST =
        AUTO_W'((AUTO_SCROLL_CYCLES > 0) ? AUTO_SCROLL_CYCLES - 1 : 0);

    pager_state_e          state_q, state_d;
    logic [DIGEST_W-1:0]   digest_q, digest_d;
    logic [PAGE_IDX_W-1:0] page_q, page_d;
    logic                  valid_q, valid_d;
    logic                  tick_q, tick_d;
    logic [AUTO_W-1:0]     auto_cnt_q, auto_cnt_d;
    logic                  rd_q;
    logic [1:0]            auto_sync_q;

    logic next_press, prev_press;
    logic capture, man_next, man_prev, auto_active;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
        .clk   (clk),
        .rst   (rst),
        .btn   (next_page),
        .press (next_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev_db (
        .clk   (clk),
        .rst   (rst),
        .btn   (prev_page),
        .press (prev_press)
    );

    assign capture     = rounds_done & ~rd_q;
    assign man_next    = next_press & ~prev_press;
    assign man_prev    = prev_press & ~next_press;
    assign auto_active = AUTO_ON & auto_sync_q[1];

    // Next-state: capture beats any press, a manual step beats the auto timer.
    always_comb begin
        state_d    = state_q;
        digest_d   = digest_q;
        page_d     = page_q;
        valid_d    = valid_q;
        tick_d     = 1'b0;
        auto_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d  = SHOW;
                    digest_d = hash;
                    page_d   = '0;
                    valid_d  = 1'b1;
                    tick_d   = 1'b1;
                end
            end
            SHOW: begin
                if (capture) begin
                    digest_d = hash;
                    page_d   = '0;
                    tick_d   = 1'b1;
                end else if (man_next) begin
                    page_d = page_q + PAGE_IDX_W'(1);
                    tick_d = 1'b1;
                end else if (man_prev) begin
                    page_d = page_q - PAGE_IDX_W'(1);
                    tick_d = 1'b1;
                end else if (auto_active) begin
                    if (auto_cnt_q == AUTO_LAST) begin
                        page_d = page_q + PAGE_IDX_W'(1);
                        tick_d = 1'b1;
                    end else begin
                        auto_cnt_d = auto_cnt_q + AUTO_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pager state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            digest_q    <= '0;
            page_q      <= '0;
            valid_q     <= 1'b0;
            tick_q      <= 1'b0;
            auto_cnt_q  <= '0;
            rd_q        <= 1'b0;
            auto_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            digest_q    <= digest_d;
            page_q      <= page_d;
            valid_q     <= valid_d;
            tick_q      <= tick_d;
            auto_cnt_q  <= auto_cnt_d;
            rd_q        <= rounds_done;
            auto_sync_q <= {auto_sync_q[0], auto_en};
        end
    end

    // Page 0 is the most significant word (H0).
    always_comb begin
        page_nibbles = '0;
        for (int i = 0; i < NUM_PAGES; i++) begin
            if (page_q == PAGE_IDX_W'(i)) begin
                page_nibbles = digest_q[PAGE_W*(NUM_PAGES-1-i) +: PAGE_W];
            end
        end
    end

    assign page_idx     = page_q;
    assign digest_valid = valid_q;
    assign page_tick    = tick_q;

endmodule

// File: tb/tb_hash_digest_pager.sv
// Directed bench for hash_digest_pager with short debounce and auto-scroll periods.
module tb_hash_digest_pager;

    localparam logic [255:0] H_VEC =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rounds_done = 1'b0;
    logic [255:0] hash = H_VEC;
    logic         next_page = 1'b0;
    logic         prev_page = 1'b0;
    logic         auto_en = 1'b0;
    logic [31:0]  page_nibbles;
    logic [2:0]   page_idx;
    logic         digest_valid;
    logic         page_tick;

    int vectors = 0;
    int errors  = 0;
    int exp_page = 0;

    hash_digest_pager #(.DEBOUNCE_CYCLES(4), .AUTO_SCROLL_CYCLES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .rounds_done  (rounds_done),
        .hash         (hash),
        .next_page    (next_page),
        .prev_page    (prev_page),
        .auto_en      (auto_en),
        .page_nibbles (page_nibbles),
        .page_idx     (page_idx),
        .digest_valid (digest_valid),
        .page_tick    (page_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] hword(input int i);
        case (i)
            0: hword = 32'h6a09e667;
            1: hword = 32'hbb67ae85;
            2: hword = 32'h3c6ef372;
            3: hword = 32'ha54ff53a;
            4: hword = 32'h510e527f;
            5: hword = 32'h9b05688c;
            6: hword = 32'h1f83d9ab;
            default: hword = 32'h5be0cd19;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press_btn(input bit use_next, output int ticks);
        ticks = 0;
        if (use_next) next_page = 1'b1; else prev_page = 1'b1;
        repeat (8) begin cyc(); ticks += int'(page_tick); end
        next_page = 1'b0;
        prev_page = 1'b0;
        repeat (8) begin cyc(); ticks += int'(page_tick); end
    endtask

    task automatic check_page(input string name, input int ticks, input int exp_ticks);
        vectors++;
        if (page_idx !== 3'(exp_page)) begin
            errors++;
            $display("FAIL %s page_idx: got %0d want %0d", name, page_idx, exp_page);
        end
        vectors++;
        if (page_nibbles !== hword(exp_page)) begin
            errors++;
            $display("FAIL %s page_nibbles: got %h want %h", name, page_nibbles, hword(exp_page));
        end
        vectors++;
        if (ticks != exp_ticks) begin
            errors++;
            $display("FAIL %s page_tick count: got %0d want %0d", name, ticks, exp_ticks);
        end
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if ({page_nibbles, page_idx, digest_valid, page_tick} !== 37'h0) begin
            errors++;
            $display("FAIL %s outputs: got nib=%h idx=%0d valid=%b tick=%b want all 0",
                     name, page_nibbles, page_idx, digest_valid, page_tick);
        end
    endtask

    task automatic wait_tick(input string name, input int limit, output int n);
        n = 0;
        while (page_tick !== 1'b1 && n < limit) begin cyc(); n++; end
        if (page_tick !== 1'b1) begin
            vectors++;
            errors++;
            $display("FAIL %s timeout: got no page_tick within %0d cycles, want one", name, limit);
        end
    endtask

    task automatic test_reset();
        #2;
        check_zero("reset_asserted");
        cyc();
        #2 rst = 1'b0;
        repeat (5) cyc();
        check_zero("reset_released");
    endtask

    task automatic test_capture();
        rounds_done = 1'b1;
        cyc();
        vectors++;
        if (digest_valid !== 1'b1 || page_tick !== 1'b1) begin
            errors++;
            $display("FAIL capture flags: got valid=%b tick=%b want 1 1", digest_valid, page_tick);
        end
        exp_page = 0;
        check_page("capture", 0, 0);
        cyc();
        vectors++;
        if (page_tick !== 1'b0) begin
            errors++;
            $display("FAIL capture tick_width: got %b want 0", page_tick);
        end
    endtask

    task automatic test_next_wrap();
        int t;
        for (int p = 1; p <= 8; p++) begin
            press_btn(1'b1, t);
            exp_page = p % 8;
            check_page("next", t, 1);
        end
    endtask

    task automatic test_prev();
        int t;
        press_btn(1'b0, t);
        exp_page = 7;
        check_page("prev_wrap", t, 1);
    endtask

    task automatic test_bounce_and_both();
        int t = 0;
        repeat (5) begin
            next_page = 1'b1;
            repeat (3) begin cyc(); t += int'(page_tick); end
            next_page = 1'b0;
            repeat (3) begin cyc(); t += int'(page_tick); end
        end
        repeat (8) begin cyc(); t += int'(page_tick); end
        check_page("bounce", t, 0);
        t = 0;
        next_page = 1'b1;
        prev_page = 1'b1;
        repeat (8) begin cyc(); t += int'(page_tick); end
        next_page = 1'b0;
        prev_page = 1'b0;
        repeat (8) begin cyc(); t += int'(page_tick); end
        check_page("both_pressed", t, 0);
    endtask

    task automatic test_auto();
        int n;
        int t = 0;
        auto_en = 1'b1;
        wait_tick("auto_first", 60, n);
        exp_page = 0;
        check_page("auto_first", 0, 0);
        cyc();
        wait_tick("auto_interval", 40, n);
        exp_page = 1;
        check_page("auto_interval", n + 1, 16);
        repeat (5) begin cyc(); t += int'(page_tick); end
        next_page = 1'b1;
        cyc();
        wait_tick("auto_manual", 20, n);
        exp_page = 2;
        check_page("auto_manual", t, 0);
        n = 0;
        cyc();
        n++;
        while (page_tick !== 1'b1 && n < 40) begin
            if (n == 3) next_page = 1'b0;
            cyc();
            n++;
        end
        next_page = 1'b0;
        exp_page = 3;
        check_page("auto_restart", n, 16);
        auto_en = 1'b0;
        t = 0;
        repeat (30) begin cyc(); t += int'(page_tick); end
        check_page("auto_off", t, 0);
    endtask

    task automatic test_auto_idle();
        int t = 0;
        rounds_done = 1'b0;
        #2 rst = 1'b1;
        cyc();
        #2 rst = 1'b0;
        auto_en = 1'b1;
        repeat (40) begin cyc(); t += int'(page_tick); end
        auto_en = 1'b0;
        vectors++;
        if (page_idx !== 3'd0 || digest_valid !== 1'b0 || t != 0) begin
            errors++;
            $display("FAIL auto_idle: got idx=%0d valid=%b ticks=%0d want 0 0 0",
                     page_idx, digest_valid, t);
        end
    endtask

    task automatic test_recapture();
        int t;
        rounds_done = 1'b1;
        cyc();
        exp_page = 0;
        check_page("capture2", 0, 0);
        repeat (5) press_btn(1'b1, t);
        exp_page = 5;
        check_page("to_page5", t, 1);
        rounds_done = 1'b0;
        cyc();
        hash = {256{1'b1}};
        rounds_done = 1'b1;
        cyc();
        vectors++;
        if (page_idx !== 3'd0 || page_nibbles !== 32'hffffffff ||
            page_tick !== 1'b1 || digest_valid !== 1'b1) begin
            errors++;
            $display("FAIL recapture: got idx=%0d nib=%h tick=%b valid=%b want 0 ffffffff 1 1",
                     page_idx, page_nibbles, page_tick, digest_valid);
        end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        hash = H_VEC;
        next_page = 1'b1;
        repeat (4) cyc();
        #2 rst = 1'b1;
        #1;
        check_zero("reset_mid");
        next_page = 1'b0;
        rounds_done = 1'b0;
        cyc();
        #2 rst = 1'b0;
        rounds_done = 1'b1;
        cyc();
        exp_page = 0;
        check_page("after_reset_capture", 0, 0);
        repeat (20) begin cyc(); t += int'(page_tick); end
        check_page("after_reset_quiet", t, 0);
    endtask

    initial begin
        test_reset();
        test_capture();
        test_next_wrap();
        test_prev();
        test_bounce_and_both();
        test_auto();
        test_auto_idle();
        test_recapture();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/hash_digest_pager.md
Name: hash_digest_pager

Overview:
- Read-side counterpart to the input padder: where the padder writes the switch-entered message into the hash core, this block reads the 256-bit digest out to the user.
- Captures the digest when the round engine signals completion and holds it in its own register.
- Presents the digest one 32-bit page (8 hex nibbles) at a time for the eight seven-segment display drivers.
- Pages are stepped by debounced next/prev push-buttons, or by an optional auto-scroll timer.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles a raw button level must hold before it is accepted (20 ms at 50 MHz).
- AUTO_SCROLL_CYCLES, 50_000_000, cycles per page in auto-scroll mode; 0 disables auto-scroll entirely.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- rounds_done  in  1  level from the round engine; high while the digest is valid.
- hash  in  256  digest from the round engine; hash[255:224] is H0.
- next_page  in  1  raw push-button, active-high, asynchronous to clk.
- prev_page  in  1  raw push-button, active-high, asynchronous to clk.
- auto_en  in  1  auto-scroll enable switch (synchronised internally).
- page_nibbles  out  32  current page; [31:28] drives the leftmost display.
- page_idx  out  3  current page number, 0..7.
- digest_valid  out  1  high once a digest has been captured.
- page_tick  out  1  one-cycle pulse on every page change or capture.

Behaviour:
- Reset (async, any state): state=IDLE, digest register=0, page_idx=0, digest_valid=0, page_tick=0, auto counter=0, debouncer outputs=0, rounds_done edge register=0. page_nibbles therefore reads 0.
- Synchronisation: next_page, prev_page and auto_en each pass through a 2-flop synchroniser before use.
- Debounce: the accepted level changes only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles. A "press" is a 0->1 edge of the accepted level.
- Capture trigger: rounds_done=1 while its registered previous value is 0.
- On the capture clock edge:
  - digest register <= hash; page_idx <= 0; digest_valid <= 1; page_tick <= 1; auto counter <= 0.
  - page_nibbles is valid immediately after that edge (combinational mux of registers; no further latency).
- States:
  - IDLE: no digest held. Presses and auto-scroll are ignored. Capture trigger -> SHOW.
  - SHOW: digest held.
    - A new capture trigger re-captures (new digest, page 0), so a second hash run is shown from the start.
    - Remains in SHOW until reset.
- Paging in SHOW:
  - next press: page_idx+1, wrapping 7->0.
  - prev press: page_idx-1, wrapping 0->7.
  - Presses on next and prev in the same cycle: no change and no page_tick.
  - Capture trigger coinciding with any press: the capture wins; page=0.
- page_nibbles = digest[255-32*page_idx -: 32], so page 0 = H0 and page 7 = H7.
- Auto-scroll (SHOW, auto_en synchronised high, AUTO_SCROLL_CYCLES!=0):
  - The counter increments every cycle.
  - When it reaches AUTO_SCROLL_CYCLES-1, the page advances as for a next press and the counter clears.
  - A manual step, a capture, or auto_en low clears the counter.
  - A manual press coinciding with the terminal count applies only once.
- page_tick: high for exactly one cycle after each edge on which page_idx changed or a capture occurred; otherwise 0.
- Mid-operation reset: all of the above reset values apply at once, and any debounce in progress is discarded.

Decomposition:
- Shared package sha_pkg:
  - DIGEST_W=256, PAGE_W=32, NUM_PAGES=8, PAGE_IDX_W=3.
  - pager state enum {IDLE, SHOW}.
- One sub-module, button_debouncer (synchroniser + stable counter + rising-edge pulse, parameter DEBOUNCE_CYCLES).
  - Instantiated twice, for next_page and prev_page.
  - auto_en uses only a bare 2-flop synchroniser.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, AUTO_SCROLL_CYCLES=16; hash = 6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19):
- Reset, then raise rounds_done -> one cycle later: digest_valid=1, page_idx=0, page_nibbles=6a09e667, page_tick pulses once. Before this: all outputs 0.
- Press next 8 times, each held 8 cycles -> pages show bb67ae85, 3c6ef372, …, 5be0cd19, then wrap to 6a09e667. One page_tick per press.
- From page 0, press prev -> page_idx=7, page_nibbles=5be0cd19.
- Bounce next for 3 cycles, release, and repeat 5 times -> no page change. Press next and prev together for 8 cycles -> no change, no page_tick.
- auto_en=1 in SHOW -> page advances every 16 cycles (0->1->2…). A manual next mid-count restarts the 16-cycle interval. With auto_en=1 in IDLE -> page_idx stays 0.
- In SHOW at page 5, drop rounds_done, change hash to all 0xFF and raise rounds_done -> page_idx=0, page_nibbles=ffffffff. Assert rst mid-debounce -> all outputs 0 immediately, with no clock edge required.
